seq_mag_comp: RTL and testbench
===============================

# seq_mag_comp

Parametrised, multi-cycle magnitude comparator that compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first. It supports unsigned and two's-complement modes and uses a start/busy/done handshake. It replaces single-cycle combinational comparators on wide datapaths where a full-width compare would not meet timing. The result is held on lt/gt/eq until the next accepted start.

## Interface
- WIDTH, 16, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; accepted only when busy=0.
- a  in  WIDTH  operand A, sampled on the accepting edge.
- b  in  WIDTH  operand B, sampled on the accepting edge.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled on the accepting edge.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse when the result becomes valid.
- lt  out  1  A < B.
- gt  out  1  A > B.
- eq  out  1  A == B.

## Operation
- The FSM has two states, IDLE and CMP. The reset state is IDLE.
- IDLE → CMP happens on an edge where start=1.
  - Operands and mode are captured into internal registers.
  - The chunk index is set to N-1 (MSB chunk).
  - lt, gt and eq are cleared to 0.
  - busy is set to 1.
- In CMP, each edge compares chunk[idx] of A against chunk[idx] of B.
  - Signed mode: for the MSB chunk only, the top bit of each operand is inverted before the compare (offset-binary). Lower chunks are always compared unsigned.
  - If the chunks differ: set lt or gt, move to IDLE, busy=0, done=1. This exit is taken only when early exit is compiled in (see Configuration); otherwise the first difference is latched and the compare continues.
  - If the chunks are equal and idx=0: resolve. eq=1 if no difference was latched; otherwise the latched lt/gt is presented. Move to IDLE, busy=0, done=1.
  - Otherwise decrement idx and stay in CMP.
- Only the first (most significant) differing chunk determines lt/gt. Exactly one of lt/gt/eq is 1 after done.
- start while busy=1 is ignored; the captured operands are unaffected.
- Results hold in IDLE until the next accepted start.
- Reset at any time, including mid-compare: immediately IDLE; busy=done=lt=gt=eq=0; all internal state is cleared.

## Timing
- Reset values: busy=0, done=0, lt=0, gt=0, eq=0.
- Start accepted at edge 0: busy=1 after edge 0.
- Chunk k (k=0 for the MSB chunk) is evaluated at edge k+1.
- Full latency: done=1 and the result is valid after edge N; busy=0 from the same edge.
- done drops after edge N+1.
- Back-to-back: start=1 in the cycle where done=1 is accepted, because busy=0 there. The new compare begins and the outputs clear on that edge.
- CHUNK=WIDTH gives N=1: result one edge after start.
- No combinational path from inputs to outputs. All outputs are registered.

## Configuration
- SEQ_MAG_COMP_EARLY_EXIT_EN defined:
  - CMP exits on the first differing chunk.
  - Latency is (index of first differing chunk from MSB)+1 edges.
  - Equal operands still take N edges.
- Macro undefined:
  - Latency is always exactly N edges, independent of the data.
  - The first difference is held in an internal register until idx=0.
- Result values are identical in both builds.

## Test plan
- WIDTH=16, CHUNK=4, unsigned, A=0x1234, B=0x1235, start pulsed → done after edge 4 (both builds), lt=1, gt=0, eq=0.
- A=0x8000, B=0x7FFF:
  - signed_mode=0 → gt=1.
  - signed_mode=1 → lt=1.
  - Early-exit build: done after edge 1. Non-early build: done after edge 4.
- A=B=0xABCD, either mode → eq=1, done after edge 4, single-cycle done pulse; outputs hold afterwards.
- Start with A=0x0001, B=0x0000. While busy, pulse start with A=0x0000, B=0xFFFF → ignored, gt=1. Then start in the done cycle with A=0x0000, B=0x0000 → accepted, eq=1 after 4 more edges.
- Start a compare, drop rst_n after edge 2 → all outputs 0 immediately. Release, start A=0x0010, B=0x0100 → lt=1 at normal latency.
- WIDTH=8, CHUNK=8, signed_mode=1, A=0xFF, B=0x01 → lt=1, done after edge 1.

Source files
------------

// File: rtl/seq_mag_comp.sv
// Multi-cycle WIDTH-bit magnitude comparator (unsigned / two's complement), CHUNK bits per cycle, MSB first.
// Latency: WIDTH/CHUNK edges from accepted start to done; with SEQ_MAG_COMP_EARLY_EXIT_EN, first differing chunk index + 1.
// Backpressure: start is ignored while busy; lt/gt/eq hold until the next accepted start.
module seq_mag_comp #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {IDLE, CMP} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic             chunk_ne;
    logic             chunk_lt;

    // Signed mode is folded in at capture: flipping the sign bit maps
    // two's complement onto offset binary, so every chunk compares unsigned.
    assign a_sh     = a_q >> (CHUNK * int'(idx));
    assign b_sh     = b_q >> (CHUNK * int'(idx));
    assign a_c      = a_sh[CHUNK-1:0];
    assign b_c      = b_sh[CHUNK-1:0];
    assign chunk_ne = (a_c != b_c);
    assign chunk_lt = (a_c < b_c);

`ifndef SEQ_MAG_COMP_EARLY_EXIT_EN
    logic diff_seen;
    logic diff_lt;
    logic fin_ne;
    logic fin_lt;

    // Most significant difference wins; a lower-chunk difference never overrides it.
    assign fin_ne = diff_seen | chunk_ne;
    assign fin_lt = diff_seen ? diff_lt : chunk_lt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            lt    <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
`ifndef SEQ_MAG_COMP_EARLY_EXIT_EN
            diff_seen <= 1'b0;
            diff_lt   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= signed_mode ? (a ^ MSB_MASK) : a;
                        b_q   <= signed_mode ? (b ^ MSB_MASK) : b;
                        idx   <= IDXW'(N - 1);
                        lt    <= 1'b0;
                        gt    <= 1'b0;
                        eq    <= 1'b0;
                        busy  <= 1'b1;
                        state <= CMP;
`ifndef SEQ_MAG_COMP_EARLY_EXIT_EN
                        diff_seen <= 1'b0;
                        diff_lt   <= 1'b0;
`endif
                    end
                end
                CMP: begin
`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
                    if (chunk_ne || idx == '0) begin
                        lt    <= chunk_ne & chunk_lt;
                        gt    <= chunk_ne & ~chunk_lt;
                        eq    <= ~chunk_ne;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
`else
                    if (chunk_ne && !diff_seen) begin
                        diff_seen <= 1'b1;
                        diff_lt   <= chunk_lt;
                    end
                    if (idx == '0) begin
                        lt    <= fin_ne & fin_lt;
                        gt    <= fin_ne & ~fin_lt;
                        eq    <= ~fin_ne;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_comp.sv
// Randomized + directed bench for seq_mag_comp (16/4 and 8/8 instances) against a cycle-level reference model.
module tb_seq_mag_comp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        signed_mode = 1'b0;
    logic        busy, done, lt, gt, eq;

    logic        s_start = 1'b0;
    logic [7:0]  s_a = '0;
    logic [7:0]  s_b = '0;
    logic        s_sm = 1'b0;
    logic        s_busy, s_done, s_lt, s_gt, s_eq;

    int n_chk = 0;
    int n_fail = 0;

`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
    localparam int LAT_MSB = 1;
    localparam int LAT_2ND = 2;
`else
    localparam int LAT_MSB = 4;
    localparam int LAT_2ND = 4;
`endif

    seq_mag_comp #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(busy), .done(done),
        .lt(lt), .gt(gt), .eq(eq)
    );

    seq_mag_comp #(.WIDTH(8), .CHUNK(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .a(s_a), .b(s_b),
        .signed_mode(s_sm), .busy(s_busy), .done(s_done),
        .lt(s_lt), .gt(s_gt), .eq(s_eq)
    );

    always #5 clk = ~clk;

    // {lt,gt,eq} of a w-bit compare; left-aligning preserves ordering in both modes.
    function automatic logic [2:0] ref_cmp(input logic [15:0] x, input logic [15:0] y,
                                           input logic sm, input int w);
        logic [15:0] xs, ys;
        xs = x << (16 - w);
        ys = y << (16 - w);
        if (sm) begin
            if ($signed(xs) < $signed(ys)) return 3'b100;
            if ($signed(xs) > $signed(ys)) return 3'b010;
        end else begin
            if (xs < ys) return 3'b100;
            if (xs > ys) return 3'b010;
        end
        return 3'b001;
    endfunction

    function automatic int ref_lat(input logic [15:0] x, input logic [15:0] y, input int w, input int c);
        logic [31:0] d, t, m;
        int first;
        first = w / c;
        d = 32'((x ^ y) << (16 - w));
        m = (32'd1 << c) - 1;
        for (int k = w / c - 1; k >= 0; k--) begin
            t = d >> (16 - (k + 1) * c);
            if ((t & m) != 0) first = k + 1;
        end
`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
        return first;
`else
        return (first > 0) ? w / c : 0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model for the 16/4 instance: transaction level, countdown of the expected latency.
    logic       m_busy = 1'b0, m_done = 1'b0, m_lt = 1'b0, m_gt = 1'b0, m_eq = 1'b0;
    logic [2:0] m_pend = '0;
    int         m_rem = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_lt <= 1'b0; m_gt <= 1'b0; m_eq <= 1'b0;
            m_rem  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    {m_lt, m_gt, m_eq} <= m_pend;
                end
                m_rem <= m_rem - 1;
            end else if (start) begin
                m_pend <= ref_cmp(a, b, signed_mode, 16);
                m_rem  <= (a == b) ? 4 : ref_lat(a, b, 16, 4);
                m_busy <= 1'b1;
                {m_lt, m_gt, m_eq} <= 3'b000;
            end
        end
    end

    always @(negedge clk)
        chk("cycle", {27'd0, busy, done, lt, gt, eq}, {27'd0, m_busy, m_done, m_lt, m_gt, m_eq});

    task automatic do_start(input logic [15:0] x, input logic [15:0] y, input logic sm);
        a = x; b = y; signed_mode = sm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic s_run(input logic [7:0] x, input logic [7:0] y, input logic sm, input string nm);
        s_a = x; s_b = y; s_sm = sm; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk({nm, "_busy"}, {31'd0, s_busy}, 32'd1);
        @(negedge clk);
        chk({nm, "_done"}, {30'd0, s_busy, s_done}, 32'd1);
        chk({nm, "_res"}, {29'd0, s_lt, s_gt, s_eq}, {29'd0, ref_cmp({8'd0, x}, {8'd0, y}, sm, 8)});
    endtask

    initial begin
        int c;
        logic [15:0] ra;
        repeat (3) @(negedge clk);
        chk("reset", {27'd0, busy, done, lt, gt, eq}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_start(16'h1234, 16'h1235, 1'b0);
        wait_done(c);
        chk("t1_lat", c, 4);
        chk("t1_res", {29'd0, lt, gt, eq}, 32'b100);

        do_start(16'h8000, 16'h7FFF, 1'b0);
        wait_done(c);
        chk("t2u_lat", c, LAT_MSB);
        chk("t2u_res", {29'd0, lt, gt, eq}, 32'b010);

        do_start(16'h8000, 16'h7FFF, 1'b1);
        wait_done(c);
        chk("t2s_lat", c, LAT_MSB);
        chk("t2s_res", {29'd0, lt, gt, eq}, 32'b100);

        for (int m = 0; m < 2; m++) begin
            do_start(16'hABCD, 16'hABCD, m[0]);
            wait_done(c);
            chk("t3_lat", c, 4);
            chk("t3_res", {29'd0, lt, gt, eq}, 32'b001);
            repeat (3) begin
                @(negedge clk);
                chk("t3_hold", {28'd0, done, lt, gt, eq}, 32'b0001);
            end
        end

        do_start(16'h0001, 16'h0000, 1'b0);
        a = 16'h0000; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c);
        chk("t4_lat", c, 3);
        chk("t4_res", {29'd0, lt, gt, eq}, 32'b010);
        do_start(16'h0000, 16'h0000, 1'b0);
        chk("t4_clear", {27'd0, busy, done, lt, gt, eq}, 32'b10000);
        wait_done(c);
        chk("t4b_lat", c, 4);
        chk("t4b_res", {29'd0, lt, gt, eq}, 32'b001);

        do_start(16'h1234, 16'h1235, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("t5_rst", {27'd0, busy, done, lt, gt, eq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(16'h0010, 16'h0100, 1'b0);
        wait_done(c);
        chk("t5_lat", c, LAT_2ND);
        chk("t5_res", {29'd0, lt, gt, eq}, 32'b100);

        s_run(8'hFF, 8'h01, 1'b1, "s_lit");
        chk("s_lit_lt", {31'd0, s_lt}, 32'd1);
        for (int i = 0; i < 30; i++)
            s_run(8'($urandom), (i % 5 == 0) ? s_a : 8'($urandom), 1'($urandom), "s_rand");

        for (int i = 0; i < 1500; i++) begin
            ra = 16'($urandom);
            a = ra;
            case ($urandom_range(0, 3))
                0: b = ra;
                1: b = ra ^ (16'd1 << $urandom_range(0, 15));
                2: b = 16'($urandom);
                default: b = {ra[15:8], 8'($urandom)};
            endcase
            signed_mode = 1'($urandom);
            start = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
